// File: rtl/peripheral_uart_monitor_pkg.sv
// Shared definitions for the UART receive-side frame monitor.
//   state_t      : receiver FSM states
//   DATA_BITS    : payload bits per 8N1 frame
//   MIN_BAUD_DIV : smallest supported bit-period divider
package peripheral_uart_monitor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   localparam int DATA_BITS    = 8;
   localparam int MIN_BAUD_DIV = 4;

endpackage

// File: rtl/peripheral_uart_monitor_fifo_bb.sv
// Fall-through synchronous FIFO holding recovered bytes.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   i_push, i_din   : write request and byte
//   i_pop           : read request (ignored when empty)
//   o_dout          : head byte, forced to 0 while empty
//   o_full, o_empty : occupancy flags
//   o_level         : number of stored entries
module peripheral_uart_monitor_fifo_bb #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_push,
   input  logic [7:0]                    i_din,
   input  logic                          i_pop,
   output logic [7:0]                    o_dout,
   output logic                          o_full,
   output logic                          o_empty,
   output logic [$clog2(FIFO_DEPTH):0]   o_level
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [7:0]  r_mem [FIFO_DEPTH];
   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   logic        w_do_push;
   logic        w_do_pop;

   // Pointers carry one wrap bit so full and empty are distinguishable.
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_level = r_wr_ptr - r_rd_ptr;
   assign o_dout  = o_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];

   // A pop in the same cycle frees the slot, so a push on full still lands.
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
   end

endmodule

// File: rtl/peripheral_uart_monitor_bb.sv
// Receive-side 8N1 frame monitor for the BlackBone UART txd line.
// Ports:
//   mclk, puc_rst       : clock, synchronous active-high reset
//   uart_rxd            : asynchronous serial input
//   baud_div            : bit period in mclk cycles, latched per start edge
//   rx_data, rx_valid   : head-of-FIFO byte and non-empty flag
//   rx_ready            : consumer accept; pops when rx_valid && rx_ready
//   frame_err           : one-cycle pulse on a low stop bit
//   overrun             : one-cycle pulse when a good byte hits a full FIFO
//   fifo_level          : FIFO occupancy
module peripheral_uart_monitor_bb
   import peripheral_uart_monitor_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_W      = 16
) (
   input  logic                          mclk,
   input  logic                          puc_rst,
   input  logic                          uart_rxd,
   input  logic [DIV_W-1:0]              baud_div,
   output logic [7:0]                    rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic                          frame_err,
   output logic                          overrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   state_t           r_state, w_state_nxt;
   logic             r_sync1, r_sync2, r_hist;
   logic [DIV_W-1:0] r_div, w_div_nxt;
   logic [DIV_W-1:0] r_cnt, w_cnt_nxt;
   logic [2:0]       r_bit_idx, w_bit_nxt;
   logic [7:0]       r_shift, w_shift_nxt;
   logic             r_frame_err, r_overrun;
   logic             w_push, w_ferr, w_fall, w_tick;
   logic             w_pop, w_full, w_empty;

   // Synchroniser and history idle high so reset never fakes a start edge.
   always_ff @(posedge mclk) begin
      if (puc_rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_hist  <= 1'b1;
      end else begin
         r_sync1 <= uart_rxd;
         r_sync2 <= r_sync1;
         r_hist  <= r_sync2;
      end
   end

   assign w_fall = r_hist & ~r_sync2;
   assign w_tick = (r_cnt == '0);

   always_comb begin
      w_state_nxt = r_state;
      w_div_nxt   = r_div;
      w_cnt_nxt   = r_cnt;
      w_bit_nxt   = r_bit_idx;
      w_shift_nxt = r_shift;
      w_push      = 1'b0;
      w_ferr      = 1'b0;
      if (r_state == ST_IDLE) begin
         if (w_fall) begin
            // Half-period load puts every later sample near mid-bit.
            w_div_nxt   = baud_div;
            w_cnt_nxt   = baud_div >> 1;
            w_state_nxt = ST_START;
         end
      end else if (!w_tick) begin
         w_cnt_nxt = r_cnt - 1'b1;
      end else begin
         w_cnt_nxt = r_div - 1'b1;
         case (r_state)
            ST_START: begin
               if (r_sync2) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt = ST_DATA;
                  w_bit_nxt   = 3'd0;
               end
            end
            ST_DATA: begin
               w_shift_nxt[r_bit_idx] = r_sync2;
               if (r_bit_idx == 3'(DATA_BITS - 1)) w_state_nxt = ST_STOP;
               else                                 w_bit_nxt   = r_bit_idx + 3'd1;
            end
            ST_STOP: begin
               w_push      = r_sync2;
               w_ferr      = ~r_sync2;
               w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge mclk) begin
      if (puc_rst) begin
         r_state     <= ST_IDLE;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_frame_err <= w_ferr;
         r_overrun   <= w_push & w_full & ~w_pop;
      end
   end

   always_ff @(posedge mclk) begin
      r_div     <= w_div_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
   end

   assign w_pop = ~w_empty & rx_ready;

   peripheral_uart_monitor_fifo_bb #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (mclk),
      .rst     (puc_rst),
      .i_push  (w_push),
      .i_din   (r_shift),
      .i_pop   (w_pop),
      .o_dout  (rx_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (fifo_level)
   );

   assign rx_valid  = ~w_empty;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_peripheral_uart_monitor_bb.sv
// Bench for peripheral_uart_monitor_bb: drives 8N1 frames on uart_rxd,
// keeps a queue of expected bytes, and compares every popped byte.
module tb_peripheral_uart_monitor_bb;

   localparam int FIFO_DEPTH = 4;
   localparam int DIV_W      = 16;

   logic             mclk = 1'b0;
   logic             puc_rst;
   logic             uart_rxd;
   logic [DIV_W-1:0] baud_div;
   logic [7:0]       rx_data;
   logic             rx_valid;
   logic             rx_ready;
   logic             frame_err;
   logic             overrun;
   logic [2:0]       fifo_level;

   int n_vec  = 0;
   int n_mis  = 0;
   int n_ferr = 0;
   int n_ovr  = 0;
   logic [7:0] q[$];

   typedef struct {
      logic [7:0] data;
      int         div;
      logic       stop;
   } vec_t;

   vec_t vecs[7];

   peripheral_uart_monitor_bb #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .DIV_W      (DIV_W)
   ) dut (
      .mclk       (mclk),
      .puc_rst    (puc_rst),
      .uart_rxd   (uart_rxd),
      .baud_div   (baud_div),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .fifo_level (fifo_level)
   );

   always #5 mclk = ~mclk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   // Scoreboard: every accepted pop is matched against the oldest expected byte.
   always @(negedge mclk) begin
      if (!puc_rst) begin
         if (frame_err) n_ferr++;
         if (overrun)   n_ovr++;
         if (rx_valid && rx_ready) begin
            if (q.size() == 0) begin
               n_vec++;
               n_mis++;
               $display("FAIL unexpected_pop: got %0h, required no data", rx_data);
            end else begin
               logic [7:0] e;
               e = q.pop_front();
               chk("pop_data", {24'h0, rx_data}, {24'h0, e});
            end
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge mclk);
      #1;
   endtask

   task automatic drive_bit(input logic v, input int div);
      uart_rxd = v;
      cycles(div);
   endtask

   task automatic send_frame(input logic [7:0] d, input int div, input logic stop);
      baud_div = DIV_W'(div);
      drive_bit(1'b0, div);
      for (int i = 0; i < 8; i++) drive_bit(d[i], div);
      drive_bit(stop, div);
   endtask

   task automatic wait_empty(input string nm, input int maxc);
      int c = 0;
      while ((rx_valid || q.size() != 0) && c < maxc) begin
         cycles(1);
         c++;
      end
      chk(nm, q.size(), 0);
      chk({nm, "_level"}, {29'h0, fifo_level}, 0);
   endtask

   initial begin
      int f0, o0;
      vecs[0] = '{8'hA5, 16, 1'b1};
      vecs[1] = '{8'h01, 4,  1'b1};
      vecs[2] = '{8'h80, 5,  1'b1};
      vecs[3] = '{8'h3C, 8,  1'b0};
      vecs[4] = '{8'hFF, 7,  1'b1};
      vecs[5] = '{8'h00, 11, 1'b1};
      vecs[6] = '{8'h5A, 23, 1'b1};

      puc_rst  = 1'b1;
      uart_rxd = 1'b1;
      baud_div = 16'd16;
      rx_ready = 1'b1;
      cycles(4);
      chk("rst_valid", {31'h0, rx_valid}, 0);
      chk("rst_data",  {24'h0, rx_data}, 0);
      chk("rst_ferr",  {31'h0, frame_err}, 0);
      chk("rst_ovr",   {31'h0, overrun}, 0);
      chk("rst_level", {29'h0, fifo_level}, 0);
      puc_rst = 1'b0;
      cycles(4);

      // Single frames, consumer always ready.
      foreach (vecs[i]) begin
         f0 = n_ferr;
         if (vecs[i].stop) q.push_back(vecs[i].data);
         send_frame(vecs[i].data, vecs[i].div, vecs[i].stop);
         uart_rxd = 1'b1;
         cycles(2 * vecs[i].div);
         wait_empty("tbl_drain", 200);
         chk("tbl_ferr", n_ferr - f0, vecs[i].stop ? 0 : 1);
      end

      // Back-to-back frames into a stalled consumer fill the FIFO.
      rx_ready = 1'b0;
      f0 = n_ferr;
      o0 = n_ovr;
      foreach (vecs[i]) if (i < 4) begin
         logic [7:0] b;
         b = (i == 0) ? 8'h01 : (i == 1) ? 8'h80 : (i == 2) ? 8'hFF : 8'h00;
         q.push_back(b);
         send_frame(b, 8, 1'b1);
      end
      uart_rxd = 1'b1;
      cycles(16);
      chk("b2b_level", {29'h0, fifo_level}, 4);
      chk("b2b_flags", n_ferr - f0 + n_ovr - o0, 0);
      rx_ready = 1'b1;
      wait_empty("b2b_drain", 100);

      // Fifth frame into a full FIFO is dropped with a single overrun pulse.
      rx_ready = 1'b0;
      o0 = n_ovr;
      for (int i = 0; i < 4; i++) begin
         q.push_back(8'(8'h11 * (i + 1)));
         send_frame(8'(8'h11 * (i + 1)), 8, 1'b1);
      end
      cycles(4);
      chk("ovr_before", n_ovr - o0, 0);
      send_frame(8'h55, 8, 1'b1);
      cycles(16);
      chk("ovr_pulse", n_ovr - o0, 1);
      chk("ovr_level", {29'h0, fifo_level}, 4);
      rx_ready = 1'b1;
      wait_empty("ovr_drain", 100);

      // Low stop bit, then a long break: one frame_err, nothing else.
      f0 = n_ferr;
      send_frame(8'h3C, 8, 1'b0);
      cycles(20 * 8);
      chk("brk_ferr", n_ferr - f0, 1);
      chk("brk_level", {29'h0, fifo_level}, 0);
      chk("brk_state", {30'h0, dut.r_state}, 0);
      uart_rxd = 1'b1;
      cycles(16);
      q.push_back(8'h77);
      send_frame(8'h77, 8, 1'b1);
      uart_rxd = 1'b1;
      cycles(16);
      wait_empty("brk_after", 100);
      chk("brk_ferr_total", n_ferr - f0, 1);

      // Three-cycle glitch is a false start.
      f0 = n_ferr;
      o0 = n_ovr;
      baud_div = 16'd16;
      uart_rxd = 1'b0;
      cycles(3);
      uart_rxd = 1'b1;
      cycles(40);
      chk("glitch_level", {29'h0, fifo_level}, 0);
      chk("glitch_flags", n_ferr - f0 + n_ovr - o0, 0);
      chk("glitch_idle", {30'h0, dut.r_state}, 0);

      // Reset during data bit 4 clears a held byte and the partial frame.
      rx_ready = 1'b0;
      send_frame(8'h99, 8, 1'b1);
      drive_bit(1'b0, 8);
      for (int i = 0; i < 4; i++) drive_bit(1'b1, 8);
      uart_rxd = 1'b0;
      cycles(4);
      puc_rst = 1'b1;
      q.delete();
      cycles(1);
      chk("mid_rst_valid", {31'h0, rx_valid}, 0);
      chk("mid_rst_data",  {24'h0, rx_data}, 0);
      chk("mid_rst_level", {29'h0, fifo_level}, 0);
      chk("mid_rst_flags", {30'h0, frame_err, overrun}, 0);
      uart_rxd = 1'b1;
      puc_rst  = 1'b0;
      cycles(20);
      rx_ready = 1'b1;
      f0 = n_ferr;
      q.push_back(8'h5A);
      send_frame(8'h5A, 8, 1'b1);
      uart_rxd = 1'b1;
      cycles(16);
      wait_empty("post_rst", 100);
      chk("post_rst_ferr", n_ferr - f0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish, required finish");
      $fatal(1);
   end

endmodule
